// File: rtl/enc_dec_pkg.sv
// Shared definitions for the encoder/decoder pair: FSM state codes and sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_dec_pkg;

    // FSM state encodings shared by the pulse decoder
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // Larger of two integers, used to size down-counters at elaboration
    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary code to one-hot line decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the code input.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      code_i,
    output logic [(2**SEL_W)-1:0] onehot_o
);

    localparam int OUT_W = 2**SEL_W;

    // Every SEL_W-bit value selects a real line, so no range check is needed
    assign onehot_o = OUT_W'(1) << code_i;

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Accepts select codes over valid/ready and drives the decoded one-hot line for
// HOLD_CYCLES cycles, then GAP_CYCLES low cycles. Latency: y updates 1 cycle after
// a transfer. Backpressure: in_ready low while a hold/gap is running or en is low.
module decoder_3to8_pulse
    import enc_dec_pkg::*;
#(
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      in_code,
    output logic                  in_ready,
    output logic [(2**SEL_W)-1:0] y,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CW    = $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1);

    // Reload values: the counter counts down to zero, so load N-1 for N cycles
    localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic          GAP_ZERO = 1'(GAP_CYCLES == 0);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("decoder_3to8_pulse: HOLD_CYCLES must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [OUT_W-1:0] dec_onehot;
    logic             cnt_zero;
    logic             xfer;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .code_i   (in_code),
        .onehot_o (dec_onehot)
    );

    assign cnt_zero = (cnt_q == '0);

    // Ready in IDLE, on the last GAP cycle, or on the last hold cycle when there is no gap
    assign in_ready = en & ((state_q == ST_IDLE)
                          | ((state_q == ST_GAP) & cnt_zero)
                          | (GAP_ZERO & (state_q == ST_ACTIVE) & cnt_zero));

    assign xfer = in_valid & in_ready;

    // Next-state logic: FSM, down-counter, registered one-hot and done pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;

        if (!en) begin
            // Abort: discard any hold in progress without a done pulse
            state_d = ST_IDLE;
            cnt_d   = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = HOLD_LD;
                        y_d     = dec_onehot;
                    end
                end
                ST_ACTIVE: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        // Last hold cycle finishes normally in every branch here
                        done_d = 1'b1;
                        if (xfer) begin
                            // Only reachable with no gap: reload straight into a new hold
                            state_d = ST_ACTIVE;
                            cnt_d   = HOLD_LD;
                            y_d     = dec_onehot;
                        end else if (!GAP_ZERO) begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LD;
                            y_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                            y_d     = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (xfer) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = HOLD_LD;
                        y_d     = dec_onehot;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    y_d     = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Self-checking bench for decoder_3to8_pulse: default config plus HOLD=2/GAP=0 config.
// Reference model tracks each accepted code as time windows (hold, busy, done cycle).
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_decoder_3to8_pulse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a, valid_a, ready_a, busy_a, done_a;
    logic [2:0] code_a;
    logic [7:0] y_a;
    logic       en_b, valid_b, ready_b, busy_b, done_b;
    logic [2:0] code_b;
    logic [7:0] y_b;

    decoder_3to8_pulse u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(valid_a), .in_code(code_a),
        .in_ready(ready_a), .y(y_a), .busy(busy_a), .done(done_a)
    );

    decoder_3to8_pulse #(.SEL_W(3), .HOLD_CYCLES(2), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(valid_b), .in_code(code_b),
        .in_ready(ready_b), .y(y_b), .busy(busy_b), .done(done_b)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    int sel, H, G, cyc;
    int rec_t, rec_code, rec_hold_end, rec_free;
    int done_q[$];
    int dut_acc_cnt, mdl_acc_cnt;

    logic [7:0] obs_y, exp_y;
    logic       obs_busy, obs_done, obs_ready;
    logic       exp_busy, exp_done, exp_ready;
    logic       acc;

    task automatic model_reset(input int s);
        sel          = s;
        H            = (s == 0) ? 4 : 2;
        G            = (s == 0) ? 1 : 0;
        rec_t        = -100;
        rec_code     = 0;
        rec_hold_end = -100;
        rec_free     = -100;
        done_q.delete();
        cyc          = 0;
    endtask

    // Drive one cycle of inputs, sample outputs, compute model expectations, advance model
    task automatic step(input logic e, input logic v, input logic [2:0] code);
        @(negedge clk);
        if (sel == 0) begin en_a = e; valid_a = v; code_a = code; end
        else          begin en_b = e; valid_b = v; code_b = code; end
        #1;
        if (sel == 0) begin obs_y = y_a; obs_busy = busy_a; obs_done = done_a; obs_ready = ready_a; end
        else          begin obs_y = y_b; obs_busy = busy_b; obs_done = done_b; obs_ready = ready_b; end

        while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
        exp_y     = (cyc > rec_t && cyc <= rec_hold_end) ? (8'd1 << rec_code) : 8'd0;
        exp_busy  = (cyc > rec_t && cyc <= rec_free);
        exp_done  = (done_q.size() > 0) && (done_q[0] == cyc);
        exp_ready = e && (cyc >= rec_free);
        acc       = exp_ready && v;
        if (obs_ready && v) dut_acc_cnt++;
        if (acc) mdl_acc_cnt++;

        if (!e) begin
            if (rec_hold_end > cyc) rec_hold_end = cyc;
            if (rec_free > cyc) rec_free = cyc;
            while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
        end else if (acc) begin
            rec_t        = cyc;
            rec_code     = int'(code);
            rec_hold_end = cyc + H;
            rec_free     = cyc + H + G;
            done_q.push_back(cyc + H + 1);
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a = 1'b0; valid_a = 1'b0; code_a = '0;
        en_b = 1'b1; valid_b = 1'b0; code_b = '0;
        #12;
        if ({y_a, busy_a, done_a} !== 10'd0) begin
            errors++; $display("FAIL reset_a y/busy/done got %h/%b/%b want 00/0/0", y_a, busy_a, done_a);
        end
        checks++;
        if ({y_b, busy_b, done_b} !== 10'd0) begin
            errors++; $display("FAIL reset_b y/busy/done got %h/%b/%b want 00/0/0", y_b, busy_b, done_b);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);

        // Start a hold, then reset asynchronously mid-cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i == 0, 3'd3);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL reset_pre cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
        end
        if (y_a !== 8'h08) begin
            errors++; $display("FAIL reset_hold_active y got %h want 08", y_a);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({y_a, busy_a, done_a} !== 10'd0) begin
            errors++; $display("FAIL reset_async y/busy/done got %h/%b/%b want 00/0/0", y_a, busy_a, done_a);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);
        step(1'b1, 1'b0, 3'd0);
        if (obs_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready in_ready got %b want 1", obs_ready);
        end
        checks++;
    endtask

    task automatic test_single();
        logic [7:0] ey;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, 3'd5);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL single_model cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
            ey = (i >= 1 && i <= 4) ? 8'h20 : 8'h00;
            if (obs_y !== ey || obs_done !== (i == 5)) begin
                errors++;
                $display("FAIL single_y cyc=%0d y/done got %h/%b want %h/%b", i, obs_y, obs_done, ey, i == 5);
            end
            checks++;
            if (i == 5 && (obs_busy !== 1'b1 || obs_ready !== 1'b1)) begin
                errors++; $display("FAIL single_gap busy/rdy got %b/%b want 1/1", obs_busy, obs_ready);
            end
            if (i == 6 && (obs_busy !== 1'b0 || obs_ready !== 1'b1)) begin
                errors++; $display("FAIL single_idle busy/rdy got %b/%b want 0/1", obs_busy, obs_ready);
            end
            if (i == 5 || i == 6) checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3] = '{3'd0, 3'd7, 3'd3};
        int         acc_at [3] = '{-1, -1, -1};
        int         k = 0;
        logic [7:0] ey;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, k < 3, codes[(k < 3) ? k : 0]);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL b2b_model cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
            ey = (i >= 1 && i <= 15 && (i % 5) != 0) ? (8'd1 << codes[(i - 1) / 5]) : 8'h00;
            if (obs_y !== ey) begin
                errors++; $display("FAIL b2b_y cyc=%0d y got %h want %h", i, obs_y, ey);
            end
            checks++;
            if (k < 3 && obs_ready === 1'b1) begin
                acc_at[k] = i;
                k++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (acc_at[j] != 5 * j) begin
                errors++; $display("FAIL b2b_accept code#%0d accepted at %0d want %0d", j, acc_at[j], 5 * j);
            end
            checks++;
        end
    endtask

    task automatic test_gap0();
        logic [2:0] codes [3] = '{3'd2, 3'd2, 3'd6};
        int         k = 0;
        logic [7:0] ey;
        logic       ed;
        model_reset(1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, k < 3, codes[(k < 3) ? k : 0]);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL gap0_model cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
            ey = (i >= 1 && i <= 4) ? 8'h04 : ((i >= 5 && i <= 6) ? 8'h40 : 8'h00);
            ed = (i == 3 || i == 5 || i == 7);
            if (obs_y !== ey || obs_done !== ed) begin
                errors++; $display("FAIL gap0_y cyc=%0d y/done got %h/%b want %h/%b", i, obs_y, obs_done, ey, ed);
            end
            checks++;
            if (k < 3 && obs_ready === 1'b1) k++;
        end
        model_reset(0);
    endtask

    task automatic test_abort();
        logic e, v;
        for (int i = 0; i < 13; i++) begin
            e = !(i >= 2 && i <= 5);
            v = (i == 0) || (i >= 3 && i <= 6);
            step(e, v, (i == 0) ? 3'd1 : 3'd4);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL abort_model cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
            if (i == 2 && obs_y !== 8'h02) begin
                errors++; $display("FAIL abort_hold y got %h want 02", obs_y);
            end
            if (i == 3 && (obs_y !== 8'h00 || obs_busy !== 1'b0)) begin
                errors++; $display("FAIL abort_clear y/busy got %h/%b want 00/0", obs_y, obs_busy);
            end
            if (i <= 10 && obs_done !== 1'b0) begin
                errors++; $display("FAIL abort_nodone cyc=%0d done got %b want 0", i, obs_done);
            end
            if (i >= 2 && i <= 5 && obs_ready !== 1'b0) begin
                errors++; $display("FAIL abort_rdy cyc=%0d in_ready got %b want 0", i, obs_ready);
            end
            if (i == 6 && obs_ready !== 1'b1) begin
                errors++; $display("FAIL abort_resume in_ready got %b want 1", obs_ready);
            end
            if (i == 2 || i == 3 || i == 6) checks++;
            if (i <= 10) checks++;
            if (i >= 2 && i <= 5) checks++;
        end
    endtask

    task automatic test_sweep(input int s);
        logic       e, v;
        logic [2:0] code;
        logic [7:0] seen = 8'h00;
        int         k = 0;
        model_reset(s);
        dut_acc_cnt = 0;
        mdl_acc_cnt = 0;
        for (int i = 0; i < 408; i++) begin
            e    = (i >= 400) || ($urandom_range(0, 15) != 0);
            v    = (i < 400) && ($urandom_range(0, 1) == 1);
            code = (k < 8) ? 3'(k) : 3'($urandom_range(0, 7));
            step(e, v, code);
            if ({obs_y, obs_busy, obs_done, obs_ready} !== {exp_y, exp_busy, exp_done, exp_ready}) begin
                errors++;
                $display("FAIL sweep%0d_model cyc=%0d y/busy/done/rdy got %h/%b/%b/%b want %h/%b/%b/%b",
                         s, i, obs_y, obs_busy, obs_done, obs_ready, exp_y, exp_busy, exp_done, exp_ready);
            end
            checks++;
            if (!$onehot0(obs_y)) begin
                errors++; $display("FAIL sweep%0d_onehot cyc=%0d y got %h want at most one bit", s, i, obs_y);
            end
            checks++;
            seen = seen | obs_y;
            if (v && obs_ready === 1'b1) k++;
        end
        if (dut_acc_cnt != mdl_acc_cnt) begin
            errors++; $display("FAIL sweep%0d_count transfers got %0d want %0d", s, dut_acc_cnt, mdl_acc_cnt);
        end
        checks++;
        if (seen !== 8'hFF) begin
            errors++; $display("FAIL sweep%0d_codes lines seen got %h want ff", s, seen);
        end
        checks++;
        model_reset(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_abort();
        test_sweep(0);
        test_sweep(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
